ex_lane_stage: RTL and testbench

EX_LANE_STAGE -- requirements
Module: ex_lane_stage

---
 rtl/ex_lane_stage.sv | 151 +++++++++++++++
 tb/tb_ex_lane_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_lane_stage.sv
// rtl/ex_lane_stage.sv - multi-lane execute stage register with a shared, age-ordered data SRAM port
//
// Purpose: holds one issue bundle of LANES instructions in the execute stage and
// serialises the bundle's memory requests onto a single data SRAM port, oldest
// lane first, stalling the stage until only the last request remains.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous pipeline flush
//   stall               pipeline stall vector (1 = stop), bit EX_IDX owned here
//   id_bus/id_valid     incoming bundle lanes and per-lane valid
//   id_oldest           index of the program-order-oldest incoming lane
//   lane_bus/valid/oldest  registered bundle presented to the lane units
//   mem_req, mem_*_i    per-lane SRAM request fields from the lane units
//   data_sram_*         the single shared data port
//   mem_grant           one-hot lane currently driving the data port
//   stallreq_for_ex     more than one request still pending in the held bundle
//   bundle_done         bundle may advance this cycle
module ex_lane_stage #(
   parameter int LANES    = 2,
   parameter int LANE_WD  = 251,
   parameter int STALL_WD = 6,
   parameter int EX_IDX   = 3,
   localparam int OW      = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [STALL_WD-1:0]      stall,
   input  logic [LANES*LANE_WD-1:0] id_bus,
   input  logic [LANES-1:0]         id_valid,
   input  logic [OW-1:0]            id_oldest,
   output logic [LANES*LANE_WD-1:0] lane_bus,
   output logic [LANES-1:0]         lane_valid,
   output logic [OW-1:0]            lane_oldest,
   input  logic [LANES-1:0]         mem_req,
   input  logic [LANES*4-1:0]       mem_wen_i,
   input  logic [LANES*32-1:0]      mem_addr_i,
   input  logic [LANES*32-1:0]      mem_wdata_i,
   output logic                     data_sram_en,
   output logic [3:0]               data_sram_wen,
   output logic [31:0]              data_sram_addr,
   output logic [31:0]              data_sram_wdata,
   output logic [LANES-1:0]         mem_grant,
   output logic                     stallreq_for_ex,
   output logic                     bundle_done
);

   logic [LANES*LANE_WD-1:0] lane_bus_q, lane_bus_d;
   logic [LANES-1:0]         lane_valid_q, lane_valid_d;
   logic [OW-1:0]            lane_oldest_q, lane_oldest_d;
   logic [LANES-1:0]         served_q, served_d;

   logic [LANES-1:0]         pending;
   logic [LANES-1:0]         grant;
   int                       pend_cnt;
   logic                     found;

   // Only two stall bits matter here; the rest are folded away on purpose.
   logic                     stall_unused;
   assign stall_unused = ^stall;

   assign pending = lane_valid_q & mem_req & ~served_q;

   // Age-ordered search: rank k is lane (oldest + k) mod LANES.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         for (int j = 0; j < LANES; j++) begin
            if (!found && pending[j] && (j == ((int'(lane_oldest_q) + k) % LANES))) begin
               grant[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      pend_cnt = 0;
      for (int j = 0; j < LANES; j++) begin
         if (pending[j]) pend_cnt = pend_cnt + 1;
      end
   end

   // And-or mux: grant is one-hot or zero, so an idle port reads all zero.
   always_comb begin
      data_sram_wen   = '0;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      for (int j = 0; j < LANES; j++) begin
         if (grant[j]) begin
            data_sram_wen   = data_sram_wen   | mem_wen_i[j*4 +: 4];
            data_sram_addr  = data_sram_addr  | mem_addr_i[j*32 +: 32];
            data_sram_wdata = data_sram_wdata | mem_wdata_i[j*32 +: 32];
         end
      end
   end

   assign data_sram_en    = |grant;
   assign mem_grant       = grant;
   assign stallreq_for_ex = (pend_cnt >= 2);
   assign bundle_done     = (pend_cnt <= 1) && (|lane_valid_q);

   assign lane_bus    = lane_bus_q;
   assign lane_valid  = lane_valid_q;
   assign lane_oldest = lane_oldest_q;

   always_comb begin
      lane_bus_d    = lane_bus_q;
      lane_valid_d  = lane_valid_q;
      lane_oldest_d = lane_oldest_q;
      // While holding, the lane granted this cycle is marked done at the edge.
      served_d      = served_q | grant;
      if (flush) begin
         lane_bus_d    = '0;
         lane_valid_d  = '0;
         lane_oldest_d = '0;
         served_d      = '0;
      end else if (stall[EX_IDX] && !stall[EX_IDX+1]) begin
         // Upstream stopped but downstream moves on: insert a bubble.
         lane_bus_d    = '0;
         lane_valid_d  = '0;
         lane_oldest_d = '0;
         served_d      = '0;
      end else if (!stall[EX_IDX]) begin
         lane_valid_d  = id_valid;
         lane_oldest_d = id_oldest;
         served_d      = '0;
         for (int j = 0; j < LANES; j++) begin
            lane_bus_d[j*LANE_WD +: LANE_WD] = id_valid[j] ? id_bus[j*LANE_WD +: LANE_WD]
                                                           : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_bus_q    <= '0;
         lane_valid_q  <= '0;
         lane_oldest_q <= '0;
         served_q      <= '0;
      end else begin
         lane_bus_q    <= lane_bus_d;
         lane_valid_q  <= lane_valid_d;
         lane_oldest_q <= lane_oldest_d;
         served_q      <= served_d;
      end
   end

endmodule

// File: tb/tb_ex_lane_stage.sv
// tb/tb_ex_lane_stage.sv - scoreboard bench for ex_lane_stage (2-lane and 4-lane instances)
module tb_ex_lane_stage;

   localparam int W = 16;
   typedef logic [73:0] v_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input v_t act, input v_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- 2-lane instance ----------------
   logic           rst2, flush2;
   logic [5:0]     stall_base2, stall2;
   logic [2*W-1:0] id_bus2, lane_bus2;
   logic [1:0]     id_valid2, lane_valid2, mem_req2, grant2;
   logic [0:0]     id_oldest2, lane_oldest2;
   logic [7:0]     mem_wen2;
   logic [63:0]    mem_addr2, mem_wdata2;
   logic           en2, sreq2, done2;
   logic [3:0]     wen2;
   logic [31:0]    addr2, wdata2;

   // Downstream control reacts to this stage's own stall request.
   assign stall2 = stall_base2 | (sreq2 ? 6'b011000 : 6'b000000);

   for (genvar i = 0; i < 2; i++) begin : g_lane2
      assign mem_req2[i]          = lane_bus2[i*W];
      assign mem_wen2[i*4 +: 4]   = lane_bus2[i*W+1 +: 4];
      assign mem_addr2[i*32 +: 32]  = {16'hA000, lane_bus2[i*W +: W]};
      assign mem_wdata2[i*32 +: 32] = ~{16'hA000, lane_bus2[i*W +: W]};
   end

   ex_lane_stage #(.LANES(2), .LANE_WD(W), .STALL_WD(6), .EX_IDX(3)) u_dut2 (
      .clk(clk), .rst(rst2), .flush(flush2), .stall(stall2),
      .id_bus(id_bus2), .id_valid(id_valid2), .id_oldest(id_oldest2),
      .lane_bus(lane_bus2), .lane_valid(lane_valid2), .lane_oldest(lane_oldest2),
      .mem_req(mem_req2), .mem_wen_i(mem_wen2), .mem_addr_i(mem_addr2), .mem_wdata_i(mem_wdata2),
      .data_sram_en(en2), .data_sram_wen(wen2), .data_sram_addr(addr2), .data_sram_wdata(wdata2),
      .mem_grant(grant2), .stallreq_for_ex(sreq2), .bundle_done(done2)
   );

   // ---------------- 4-lane instance ----------------
   logic           rst4, flush4;
   logic [5:0]     stall_base4, stall4;
   logic [4*W-1:0] id_bus4, lane_bus4;
   logic [3:0]     id_valid4, lane_valid4, mem_req4, grant4;
   logic [1:0]     id_oldest4, lane_oldest4;
   logic [15:0]    mem_wen4;
   logic [127:0]   mem_addr4, mem_wdata4;
   logic           en4, sreq4, done4;
   logic [3:0]     wen4;
   logic [31:0]    addr4, wdata4;

   assign stall4 = stall_base4 | (sreq4 ? 6'b011000 : 6'b000000);

   for (genvar i = 0; i < 4; i++) begin : g_lane4
      assign mem_req4[i]            = lane_bus4[i*W];
      assign mem_wen4[i*4 +: 4]     = lane_bus4[i*W+1 +: 4];
      assign mem_addr4[i*32 +: 32]  = {16'hA000, lane_bus4[i*W +: W]};
      assign mem_wdata4[i*32 +: 32] = ~{16'hA000, lane_bus4[i*W +: W]};
   end

   ex_lane_stage #(.LANES(4), .LANE_WD(W), .STALL_WD(6), .EX_IDX(3)) u_dut4 (
      .clk(clk), .rst(rst4), .flush(flush4), .stall(stall4),
      .id_bus(id_bus4), .id_valid(id_valid4), .id_oldest(id_oldest4),
      .lane_bus(lane_bus4), .lane_valid(lane_valid4), .lane_oldest(lane_oldest4),
      .mem_req(mem_req4), .mem_wen_i(mem_wen4), .mem_addr_i(mem_addr4), .mem_wdata_i(mem_wdata4),
      .data_sram_en(en4), .data_sram_wen(wen4), .data_sram_addr(addr4), .data_sram_wdata(wdata4),
      .mem_grant(grant4), .stallreq_for_ex(sreq4), .bundle_done(done4)
   );

   // ---------------- scoreboards: {grant[3:0], wen, addr, wdata, stallreq, done} ----------------
   v_t q2[$];
   v_t q4[$];

   always @(negedge clk) begin
      if (en2) begin
         if (q2.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut2 unexpected access: grant %b addr %h expected none", grant2, addr2);
         end else begin
            check("dut2 access", {2'b00, grant2, wen2, addr2, wdata2, sreq2, done2}, q2.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (en4) begin
         if (q4.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut4 unexpected access: grant %b addr %h expected none", grant4, addr4);
         end else begin
            check("dut4 access", {grant4, wen4, addr4, wdata4, sreq4, done4}, q4.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain2();
      int n = 0;
      while (q2.size() != 0 && n < 20) begin
         step();
         n++;
      end
      check("dut2 drain", v_t'(q2.size()), v_t'(0));
   endtask

   task automatic drain4();
      int n = 0;
      while (q4.size() != 0 && n < 20) begin
         step();
         n++;
      end
      check("dut4 drain", v_t'(q4.size()), v_t'(0));
   endtask

   // Bundle A: lane0 0x0103 (wen 1), lane1 0x021F (wen F), both stores, oldest = lane1.
   task automatic issue_a();
      id_bus2     = {16'h021F, 16'h0103};
      id_valid2   = 2'b11;
      id_oldest2  = 1'b1;
      stall_base2 = 6'b0;
      step();
      id_valid2   = 2'b00;
   endtask

   localparam v_t A_L1 = {4'b0010, 4'hF, 32'hA000021F, 32'h5FFFFDE0, 1'b1, 1'b0};
   localparam v_t A_L0 = {4'b0001, 4'h1, 32'hA0000103, 32'h5FFFFEFC, 1'b0, 1'b1};

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst2 = 1'b1; flush2 = 1'b0; stall_base2 = '0;
      id_bus2 = {16'h021F, 16'h0103}; id_valid2 = 2'b11; id_oldest2 = 1'b1;
      rst4 = 1'b1; flush4 = 1'b0; stall_base4 = '0;
      id_bus4 = '0; id_valid4 = '0; id_oldest4 = '0;

      // Reset holds everything at zero even with a valid bundle offered.
      step();
      step();
      check("reset outputs", v_t'({en2, sreq2, done2, lane_valid2, grant2, lane_oldest2}), v_t'(0));
      check("reset lane_bus", v_t'(lane_bus2), v_t'(0));

      // Two-store bundle, oldest = lane1: lane1 first with stallreq, then lane0 done.
      rst2 = 1'b0;
      rst4 = 1'b0;
      q2.push_back(A_L1);
      q2.push_back(A_L0);
      step();
      id_valid2 = 2'b00;
      check("first load valid", v_t'(lane_valid2), v_t'(2'b11));
      drain2();
      step();

      // Invalid lane's bus is zeroed on load.
      id_bus2    = {16'hBEEF, 16'h0040};
      id_valid2  = 2'b01;
      id_oldest2 = 1'b0;
      step();
      id_valid2   = 2'b00;
      stall_base2 = 6'b011000;
      check("invalid lane zeroed", v_t'(lane_bus2), v_t'(32'h0000_0040));
      check("partial valid", v_t'(lane_valid2), v_t'(2'b01));
      check("single lane no stall", v_t'({sreq2, done2}), v_t'(2'b01));

      // EX and MEM stopped: hold. EX stopped, MEM running: bubble.
      step();
      check("hold valid", v_t'(lane_valid2), v_t'(2'b01));
      check("hold bus", v_t'(lane_bus2), v_t'(32'h0000_0040));
      stall_base2 = 6'b001000;
      step();
      check("bubble valid", v_t'(lane_valid2), v_t'(0));
      check("bubble bus", v_t'(lane_bus2), v_t'(0));
      stall_base2 = 6'b0;
      step();

      // Externally held after both served: no re-issue.
      q2.push_back(A_L1);
      q2.push_back(A_L0);
      issue_a();
      stall_base2 = 6'b011000;
      step();
      step();
      check("served hold idle", v_t'({en2, sreq2, done2, lane_valid2}), v_t'(5'b00111));
      step();
      check("served hold idle 2", v_t'({en2, grant2}), v_t'(0));
      stall_base2 = 6'b0;
      step();
      check("dut2 queue after hold", v_t'(q2.size()), v_t'(0));

      // Flush in the first grant cycle: access still driven, then everything cleared.
      q2.push_back(A_L1);
      issue_a();
      flush2 = 1'b1;
      step();
      flush2 = 1'b0;
      check("flush cleared", v_t'({en2, grant2, lane_valid2, sreq2, done2}), v_t'(0));
      step();
      check("dut2 queue after flush", v_t'(q2.size()), v_t'(0));

      // Asynchronous reset between edges mid-bundle.
      q2.push_back(A_L1);
      issue_a();
      #5;
      rst2 = 1'b1;
      #1;
      check("async reset outputs", v_t'({en2, grant2, lane_valid2, sreq2, done2}), v_t'(0));
      check("async reset bus", v_t'(lane_bus2), v_t'(0));
      #1;
      rst2 = 1'b0;
      step();
      step();
      step();
      check("dut2 queue after reset", v_t'(q2.size()), v_t'(0));

      // 4 lanes, lanes 0/2/3 requesting, oldest = 2: order 2, 3, 0 with wrap.
      q4.push_back({4'b0100, 4'h2, 32'hA0000025, 32'h5FFFFFDA, 1'b1, 1'b0});
      q4.push_back({4'b1000, 4'hB, 32'hA0000037, 32'h5FFFFFC8, 1'b1, 1'b0});
      q4.push_back({4'b0001, 4'h8, 32'hA0000011, 32'h5FFFFFEE, 1'b0, 1'b1});
      id_bus4    = {16'h0037, 16'h0025, 16'h0050, 16'h0011};
      id_valid4  = 4'b1111;
      id_oldest4 = 2'd2;
      step();
      id_valid4 = 4'b0000;
      check("dut4 stallreq first", v_t'(sreq4), v_t'(1));
      step();
      check("dut4 stallreq second", v_t'(sreq4), v_t'(1));
      step();
      check("dut4 stallreq last", v_t'({sreq4, done4}), v_t'(2'b01));
      drain4();
      step();

      // Single requesting lane in a 4-lane bundle: no stall at all.
      q4.push_back({4'b0010, 4'h1, 32'hA0000063, 32'h5FFFFF9C, 1'b0, 1'b1});
      id_bus4    = {16'h0000, 16'h0000, 16'h0063, 16'h0000};
      id_valid4  = 4'b0010;
      id_oldest4 = 2'd3;
      step();
      id_valid4 = 4'b0000;
      check("dut4 single lane", v_t'({sreq4, done4, lane_oldest4}), v_t'(4'b0111));
      drain4();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
